// File: rtl/digit_draw_sequencer.sv
// Countdown display (MM:SS) renderer: converts seconds to four digits, then streams
// every pixel of four 7-segment boxes to the framebuffer. Optional: LEADING_ZERO_BLANK_EN.
module digit_draw_sequencer #(
   parameter int X_ORIGIN    = 80,
   parameter int Y_ORIGIN    = 160,
   parameter int DIGIT_PITCH = 100,
   parameter int DIGIT_W     = 80,
   parameter int DIGIT_H     = 160,
   parameter int STROKE      = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] time_s,
   input  logic [1:0]  state,
   input  logic        wr_ready,
   output logic        wr_en,
   output logic [8:0]  x,
   output logic [8:0]  y,
   output logic [11:0] rgb,
   output logic        busy,
   output logic        done
);
   localparam int CW = (DIGIT_W > 1) ? $clog2(DIGIT_W) : 1;
   localparam int RW = (DIGIT_H > 1) ? $clog2(DIGIT_H) : 1;

   typedef enum logic [2:0] {IDLE, LATCH, CONV_MIN, CONV_TENS, DRAW, DONE} fsm_t;

   fsm_t          fsm;
   logic [15:0]   rem;
   logic [6:0]    mins;
   logic [1:0]    run_st;
   logic          sec_phase;
   logic [3:0]    d0, d1, d2, d3;
   logic [11:0]   colour, colour_nxt, fg;
   logic [1:0]    k, k_n, pk;
   logic [RW-1:0] row, row_n, pr;
   logic [CW-1:0] col, col_n, pc;
   logic          last;
   logic [3:0]    dig;
   logic [6:0]    segs;
   logic          seg_on, blank;
   int            rr, cc;
   logic [8:0]    px, py;
   logic [11:0]   prgb;

   // segment bits {g,f,e,d,c,b,a}
   function automatic logic [6:0] seg_lut(input logic [3:0] d);
      case (d)
         4'd0:    seg_lut = 7'h3F;
         4'd1:    seg_lut = 7'h06;
         4'd2:    seg_lut = 7'h5B;
         4'd3:    seg_lut = 7'h4F;
         4'd4:    seg_lut = 7'h66;
         4'd5:    seg_lut = 7'h6D;
         4'd6:    seg_lut = 7'h7D;
         4'd7:    seg_lut = 7'h07;
         4'd8:    seg_lut = 7'h7F;
         4'd9:    seg_lut = 7'h6F;
         default: seg_lut = 7'h00;
      endcase
   endfunction

   always_comb begin
      case (colour)
         12'h0FF: colour_nxt = 12'hF0F;
         12'hF0F: colour_nxt = 12'hFF0;
         default: colour_nxt = 12'h0FF;
      endcase
   end

   // scan counters: column inner, row middle, digit outer
   always_comb begin
      col_n = col + 1'b1;
      row_n = row;
      k_n   = k;
      if (col == CW'(DIGIT_W-1)) begin
         col_n = '0;
         row_n = row + 1'b1;
         if (row == RW'(DIGIT_H-1)) begin
            row_n = '0;
            k_n   = k + 1'b1;
         end
      end
   end

   assign last = (k == 2'd3) && (row == RW'(DIGIT_H-1)) && (col == CW'(DIGIT_W-1));

   // pixel to present next: first pixel when entering DRAW, else the successor
   assign pk = (fsm == DRAW) ? k_n   : 2'd0;
   assign pr = (fsm == DRAW) ? row_n : '0;
   assign pc = (fsm == DRAW) ? col_n : '0;

   always_comb begin
      case (pk)
         2'd0:    dig = d0;
         2'd1:    dig = d1;
         2'd2:    dig = d2;
         default: dig = d3;
      endcase
      segs = seg_lut(dig);
      rr   = int'(pr);
      cc   = int'(pc);
      seg_on = (segs[0] && rr < STROKE) ||
               (segs[1] && cc >= DIGIT_W-STROKE && rr < DIGIT_H/2) ||
               (segs[2] && cc >= DIGIT_W-STROKE && rr >= DIGIT_H/2) ||
               (segs[3] && rr >= DIGIT_H-STROKE) ||
               (segs[4] && cc < STROKE && rr >= DIGIT_H/2) ||
               (segs[5] && cc < STROKE && rr < DIGIT_H/2) ||
               (segs[6] && rr >= DIGIT_H/2-STROKE/2 && rr < DIGIT_H/2+STROKE/2);
`ifdef LEADING_ZERO_BLANK_EN
      blank = (pk == 2'd0) && (d0 == 4'd0);
`else
      blank = 1'b0;
`endif
      px   = 9'(X_ORIGIN + int'(pk) * DIGIT_PITCH + int'(pc));
      py   = 9'(Y_ORIGIN + int'(pr));
      prgb = (seg_on && !blank) ? fg : 12'h000;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm       <= IDLE;
         wr_en     <= 1'b0;
         x         <= '0;
         y         <= '0;
         rgb       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         colour    <= 12'h0FF;
         fg        <= '0;
         rem       <= '0;
         mins      <= '0;
         run_st    <= '0;
         sec_phase <= 1'b0;
         d0        <= '0;
         d1        <= '0;
         d2        <= '0;
         d3        <= '0;
         k         <= '0;
         row       <= '0;
         col       <= '0;
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: if (start) begin
               rem    <= time_s;
               run_st <= state;
               busy   <= 1'b1;
               fsm    <= LATCH;
            end
            LATCH: begin
               if (rem >= 16'd5999) rem <= 16'd5999;
               mins      <= '0;
               sec_phase <= 1'b0;
               d0        <= '0;
               d2        <= '0;
               case (run_st)
                  2'b00:   fg <= 12'h0F0;
                  2'b01:   fg <= 12'hF00;
                  2'b10:   fg <= 12'h000;
                  default: begin
                     colour <= colour_nxt;
                     fg     <= colour_nxt;
                  end
               endcase
               fsm <= CONV_MIN;
            end
            CONV_MIN:
               if (rem >= 16'd60) begin
                  rem  <= rem - 16'd60;
                  mins <= mins + 7'd1;
               end else fsm <= CONV_TENS;
            CONV_TENS:
               if (!sec_phase) begin
                  if (mins >= 7'd10) begin
                     mins <= mins - 7'd10;
                     d0   <= d0 + 4'd1;
                  end else begin
                     d1        <= mins[3:0];
                     sec_phase <= 1'b1;
                  end
               end else if (rem >= 16'd10) begin
                  rem <= rem - 16'd10;
                  d2  <= d2 + 4'd1;
               end else begin
                  d3    <= rem[3:0];
                  k     <= '0;
                  row   <= '0;
                  col   <= '0;
                  wr_en <= 1'b1;
                  x     <= px;
                  y     <= py;
                  rgb   <= prgb;
                  fsm   <= DRAW;
               end
            DRAW:
               if (wr_ready) begin
                  if (last) begin
                     wr_en <= 1'b0;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     fsm   <= DONE;
                  end else begin
                     k   <= k_n;
                     row <= row_n;
                     col <= col_n;
                     x   <= px;
                     y   <= py;
                     rgb <= prgb;
                  end
               end
            DONE:    fsm <= IDLE;
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_digit_draw_sequencer.sv
// Directed bench for digit_draw_sequencer using a reduced digit box (16x20, stroke 4).
module tb_digit_draw_sequencer;
   localparam int XO = 80, YO = 160, PITCH = 20, W = 16, H = 20, S = 4;
   localparam int NB = 4 * W * H;

   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, wr_ready = 1'b0;
   logic [15:0] time_s = '0;
   logic [1:0]  state = '0;
   logic        wr_en, busy, done;
   logic [8:0]  x, y;
   logic [11:0] rgb;

   int n_chk = 0, n_pass = 0;
   logic [8:0]  bx [NB];
   logic [8:0]  by [NB];
   logic [11:0] brgb [NB];
   int nbeats, first_cyc, last_cyc, done_cyc, unstable, order_err, lz_lit;
   logic [31:0] sig, sig0;

   always #5 clk = ~clk;

   digit_draw_sequencer #(.X_ORIGIN(XO), .Y_ORIGIN(YO), .DIGIT_PITCH(PITCH),
                          .DIGIT_W(W), .DIGIT_H(H), .STROKE(S)) dut (
      .clk(clk), .reset(reset), .start(start), .time_s(time_s), .state(state),
      .wr_ready(wr_ready), .wr_en(wr_en), .x(x), .y(y), .rgb(rgb),
      .busy(busy), .done(done));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [11:0] rgb_at(input int xx, input int yy);
      for (int i = 0; i < nbeats; i++)
         if (bx[i] == 9'(xx) && by[i] == 9'(yy)) return brgb[i];
      return 12'hFFF;
   endfunction

   // one frame at the negedge grid; abort_at >= 0 pulses reset after that many beats
   task automatic run_frame(input logic [15:0] t, input logic [1:0] st, input bit rnd,
                            input bit disturb, input int abort_at);
      logic [8:0]  px = '0, py = '0;
      logic [11:0] pr = '0;
      bit hold = 1'b0, rdy;
      int cyc, i;
      nbeats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
      unstable = 0; order_err = 0; sig = '0; lz_lit = 0;
      @(negedge clk); time_s = t; state = st; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("busy_rise", 32'(busy), 32'd1);
      cyc = 1;
      while (cyc < 6000) begin
         if (done) begin done_cyc = cyc; break; end
         if (hold && (x !== px || y !== py || rgb !== pr)) unstable++;
         if (wr_en && first_cyc < 0) first_cyc = cyc;
         if (disturb && cyc == 50) begin start = 1'b1; time_s = 16'd0; state = 2'b01; end
         if (disturb && cyc == 51) start = 1'b0;
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         wr_ready = rdy;
         if (wr_en && rdy && nbeats < NB) begin
            i = nbeats;
            bx[i] = x; by[i] = y; brgb[i] = rgb;
            if (x !== 9'(XO + (i / (W*H)) * PITCH + i % W) || y !== 9'(YO + (i % (W*H)) / W))
               order_err++;
            if (i < W*H && rgb != 12'h000) lz_lit++;
            sig = {sig[26:0], sig[31:27]} ^ {2'b00, x, y, rgb};
            nbeats++;
            last_cyc = cyc;
            if (nbeats == abort_at) begin
               reset = 1'b1;
               #1;
               chk("rst_wr_en", 32'(wr_en), 32'd0);
               chk("rst_x", 32'(x), 32'd0);
               chk("rst_y", 32'(y), 32'd0);
               chk("rst_rgb", 32'(rgb), 32'd0);
               chk("rst_busy", 32'(busy), 32'd0);
               chk("rst_done", 32'(done), 32'd0);
               @(negedge clk); @(negedge clk);
               reset = 1'b0;
               break;
            end
         end
         hold = wr_en && !rdy;
         px = x; py = y; pr = rgb;
         @(negedge clk);
         cyc++;
      end
      wr_ready = 1'b0;
   endtask

   task automatic frame_end_checks(input string tag);
      chk({tag, "_beats"}, 32'(nbeats), 32'(NB));
      chk({tag, "_order"}, 32'(order_err), 32'd0);
      chk({tag, "_latency"}, 32'(first_cyc > 0 && first_cyc <= 130), 32'd1);
      chk({tag, "_done_after_last"}, 32'(done_cyc), 32'(last_cyc + 1));
      chk({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_wr_en", 32'(wr_en), 32'd0);
      chk("reset_xy", 32'({x, y}), 32'd0);
      chk("reset_rgb", 32'(rgb), 32'd0);
      chk("reset_busy_done", 32'({busy, done}), 32'd0);
      reset = 1'b0;

      // 12:34, counting; inputs disturbed and start re-pulsed mid-frame
      run_frame(16'd754, 2'b00, 1'b0, 1'b1, -1);
      chk("f754_no_gap", 32'(last_cyc - first_cyc + 1), 32'(NB));
      chk("f754_first_x", 32'(bx[0]), 32'd80);
      chk("f754_first_y", 32'(by[0]), 32'd160);
      chk("f754_d0_corner", 32'(rgb_at(80, 160)), 32'h000);
      chk("f754_d0_seg_b", 32'(rgb_at(94, 165)), 32'h0F0);
      chk("f754_d1_seg_e", 32'(rgb_at(100, 175)), 32'h0F0);
      chk("f754_d2_no_e", 32'(rgb_at(120, 175)), 32'h000);
      chk("f754_d3_no_a", 32'(rgb_at(146, 160)), 32'h000);
      chk("f754_d3_seg_f", 32'(rgb_at(140, 165)), 32'h0F0);
      frame_end_checks("f754");

      // saturation to 99:59, stopped
      run_frame(16'd6000, 2'b01, 1'b0, 1'b0, -1);
      chk("f6000_d0_seg_a", 32'(rgb_at(85, 162)), 32'hF00);
      chk("f6000_d1_no_e", 32'(rgb_at(100, 175)), 32'h000);
      chk("f6000_d2_no_b", 32'(rgb_at(134, 165)), 32'h000);
      chk("f6000_d2_seg_f", 32'(rgb_at(120, 165)), 32'hF00);
      chk("f6000_d3_seg_d", 32'(rgb_at(145, 178)), 32'hF00);
      frame_end_checks("f6000");

      // finished-state colour cycling
      run_frame(16'd754, 2'b11, 1'b0, 1'b0, -1);
      chk("fin1_colour", 32'(rgb_at(94, 165)), 32'hF0F);
      @(negedge clk);
      run_frame(16'd754, 2'b11, 1'b0, 1'b0, -1);
      chk("fin2_colour", 32'(rgb_at(94, 165)), 32'hFF0);
      @(negedge clk);
      run_frame(16'd754, 2'b10, 1'b0, 1'b0, -1);
      chk("blank_colour", 32'(rgb_at(94, 165)), 32'h000);
      chk("blank_beats", 32'(nbeats), 32'(NB));
      @(negedge clk);
      run_frame(16'd754, 2'b11, 1'b0, 1'b0, -1);
      chk("fin3_colour", 32'(rgb_at(94, 165)), 32'h0FF);
      @(negedge clk);
      run_frame(16'd754, 2'b11, 1'b0, 1'b0, -1);
      chk("fin4_colour", 32'(rgb_at(94, 165)), 32'hF0F);
      @(negedge clk);

      // 00:00 with steady and with random ready
      run_frame(16'd0, 2'b00, 1'b0, 1'b0, -1);
      sig0 = sig;
      frame_end_checks("zero_fixed");
      run_frame(16'd0, 2'b00, 1'b1, 1'b0, -1);
      chk("zero_rand_stable", 32'(unstable), 32'd0);
      chk("zero_rand_sequence", sig, sig0);
      frame_end_checks("zero_rand");

      // reset in the middle of a frame, then 00:59
      run_frame(16'd754, 2'b00, 1'b0, 1'b0, 600);
      chk("abort_beats", 32'(nbeats), 32'd600);
      run_frame(16'd59, 2'b00, 1'b0, 1'b0, -1);
      chk("f59_first_x", 32'(bx[0]), 32'd80);
      chk("f59_first_y", 32'(by[0]), 32'd160);
      chk("f59_d1_seg_f", 32'(rgb_at(100, 165)), 32'h0F0);
      chk("f59_d2_seg_f", 32'(rgb_at(120, 165)), 32'h0F0);
      chk("f59_d2_no_b", 32'(rgb_at(134, 165)), 32'h000);
      chk("f59_d3_seg_d", 32'(rgb_at(145, 178)), 32'h0F0);
`ifdef LEADING_ZERO_BLANK_EN
      chk("f59_d0_blank_lit", 32'(lz_lit), 32'd0);
`else
      chk("f59_d0_seg_a", 32'(rgb_at(80, 160)), 32'h0F0);
`endif
      frame_end_checks("f59");

      // colour register restored by reset
      run_frame(16'd754, 2'b11, 1'b0, 1'b0, -1);
      chk("post_reset_colour", 32'(rgb_at(94, 165)), 32'hF0F);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/digit_draw_sequencer.md
Name: digit_draw_sequencer

Overview:
- Sequences rendering of the countdown display (MM:SS) into the framebuffer write port.
- On a start pulse it latches the time and run state, then converts seconds to four decimal digits with a sequential subtractor.
- It then streams every pixel of four 7-segment digit boxes as x/y/rgb write beats under a valid/ready handshake.
- Sits between the timer core and the framebuffer memory, and is the only writer to that memory.

Parameters:
- X_ORIGIN, 80: x of left edge of digit 0 (tens of minutes).
- Y_ORIGIN, 160: y of top edge of all digits.
- DIGIT_PITCH, 100: x distance between successive digit boxes.
- DIGIT_W, 80: digit box width in pixels.
- DIGIT_H, 160: digit box height in pixels.
- STROKE, 10: segment thickness in pixels.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to redraw the whole display.
- time_s  in  16  remaining time in seconds, sampled on an accepted start.
- state  in  2  timer state, sampled on an accepted start: 00 counting, 01 stopped, 10 blank, 11 finished.
- wr_ready  in  1  framebuffer can accept a beat this cycle.
- wr_en  out  1  write beat valid.
- x  out  9  pixel column.
- y  out  9  pixel row.
- rgb  out  12  pixel colour, 4:4:4.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (asynchronous): wr_en, x, y, rgb, busy and done = 0; FSM = IDLE; colour register = 0FF (cyan).
- FSM states: IDLE -> LATCH -> CONV_MIN -> CONV_TENS -> DRAW -> DONE -> IDLE.
- IDLE:
  - start=1 is accepted; busy rises next cycle.
  - start while busy is ignored, with no queueing.
- LATCH (1 cycle):
  - If time_s >= 5999, saturate to 5999, which displays 99:59.
  - Select the foreground colour: 00 -> 0F0; 01 -> F00; 10 -> 000; 11 -> advance the colour register (0FF -> F0F -> FF0 -> 0FF) and use the new value.
  - The colour register is untouched in states other than 11.
- CONV_MIN: subtract 60 per cycle while the remainder >= 60, counting minutes (0..99).
- CONV_TENS: subtract 10 per cycle from minutes, then from seconds, to give digits d0..d3.
- Conversion latency: start accept to first wr_en is at most 130 cycles.
- DRAW: scan digits d0..d3 in order, rows 0..DIGIT_H-1 outer, columns 0..DIGIT_W-1 inner.
  - x = X_ORIGIN + k*DIGIT_PITCH + col, where k is the digit index.
  - y = Y_ORIGIN + row.
  - rgb = foreground if the pixel lies in an active segment of the digit, else 000.
- Segment regions (r = row, c = col, W = DIGIT_W, H = DIGIT_H, S = STROKE):
  - a: r < S.
  - b: c >= W-S and r < H/2.
  - c: c >= W-S and r >= H/2.
  - d: r >= H-S.
  - e: c < S and r >= H/2.
  - f: c < S and r < H/2.
  - g: H/2-S/2 <= r < H/2+S/2.
- Segment patterns: standard 7-segment encoding for 0..9; 1 = b,c; 7 = a,b,c.
- Handshake:
  - wr_en stays high through DRAW.
  - x/y/rgb hold stable while wr_en=1 and wr_ready=0.
  - A beat completes on wr_en&wr_ready; the next pixel is presented the following cycle.
  - No gap cycles occur while wr_ready stays high.
- Beat count: exactly 4*DIGIT_W*DIGIT_H beats per frame (51200 at defaults).
- DONE: wr_en=0, done=1 for one cycle, busy falls in the same cycle, then return to IDLE.
- Input sampling: time_s/state changes during a frame have no effect until the next start.
- Reset mid-frame: outputs clear immediately (async) and the frame is abandoned; the colour register returns to 0FF.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when d0 == 0, digit 0 is drawn with all segments off (all 000). Beat count is unchanged.
- Undefined: d0 == 0 is drawn as the glyph "0".

Test Plan:
- time_s=754, state=00, wr_ready=1 -> digits 1,2,3,4; 51200 beats; beat (x=80,y=160) rgb=000; (x=155,y=165) rgb=0F0; done pulses exactly one cycle after the last beat; 0 idle cycles within DRAW.
- time_s=6000, state=01 -> digits 9,9,5,9 (99:59); beat (x=85,y=162) rgb=F00 (segment a of 9).
- Three successive frames with state=11 after reset -> foreground colours F0F, FF0, 0FF in that order.
- Random wr_ready toggling (50%) with time_s=0 -> x/y/rgb stable whenever wr_en&!wr_ready; beat sequence identical to the wr_ready=1 run.
- Reset asserted at beat 20000, then start with time_s=59 -> outputs 0 during reset; new frame draws 00:59 from x=80,y=160; colour 0F0 for state=00.
- time_s=59 with LEADING_ZERO_BLANK_EN defined -> all 12800 beats of digit 0 have rgb=000; undefined -> beat (x=80,y=160) rgb=foreground (segment a).
